// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and helpers for the stochastic-computing multiplier
// Purpose: FSM state type, mode/decorrelation encodings and the Sobol
// dimension-1 direction-vector helper used by sc_sobol_rng.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_mul_state_e;

  localparam logic SC_UNIPOLAR    = 1'b0;
  localparam logic SC_BIPOLAR     = 1'b1;
  localparam logic SC_DECOR_RAMP  = 1'b0;
  localparam logic SC_DECOR_SOBOL = 1'b1;

  // Dimension-1 Sobol direction vector idx for a width-bit generator:
  // v_idx = 2^(width-1-idx), i.e. a single bit walking down from the MSB.
  function automatic logic [31:0] sobol_dir(input int width, input int idx);
    return 32'd1 << (width - 1 - idx);
  endfunction

endpackage

// File: rtl/sc_sobol_rng.sv
// rtl/sc_sobol_rng.sv - gray-code Sobol dimension-1 sequence generator
// Purpose: emits the dim-1 Sobol sequence in gray-code order, first value 0.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to the first value (0); has priority over en
//   en       : advance to the next sequence value
//   seq_o    : current sequence value
module sc_sobol_rng
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] seq_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic [WIDTH-1:0] dir;

  // Direction vector at the lowest zero bit of the index counter. An
  // all-ones counter has no zero bit; the last vector then returns the
  // sequence to 0 so the generator is periodic with period 2^WIDTH.
  always_comb begin
    dir = WIDTH'(sobol_dir(WIDTH, WIDTH - 1));
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!cnt_q[i]) dir = WIDTH'(sobol_dir(WIDTH, i));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    seq_d = seq_q;
    if (clr) begin
      cnt_d = '0;
      seq_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
      seq_d = seq_q ^ dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      seq_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      seq_q <= seq_d;
    end
  end

  assign seq_o = seq_q;

endmodule

// File: rtl/sc_mul_engine.sv
// rtl/sc_mul_engine.sv - stochastic-computing multiplier with ones counter
// Purpose: latches two operands, streams 2^len product bits (AND or XNOR of
// two comparator streams) and counts the ones, with start/busy/done handshake.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start_i, abort_i             : run request / run termination
//   mode_i, decor_i, len_i       : polarity, decorrelation scheme, log2 length
//   a_i, b_i                     : operands (unsigned fractions of 2^WIDTH)
//   busy_o, bit_o, bit_vld_o     : run status and product stream
//   done_o, ones_o               : end-of-run pulse and ones count
module sc_mul_engine
  import sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENWD = $clog2(2*WIDTH+1),
  parameter int CNTWD = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic             decor_i,
  input  logic [LENWD-1:0] len_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             bit_o,
  output logic             bit_vld_o,
  output logic             done_o,
  output logic [CNTWD-1:0] ones_o
);

  localparam logic [LENWD-1:0] LEN_MAX = LENWD'(2*WIDTH);

  sc_mul_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mode_q, mode_d, decor_q, decor_d;
  logic [LENWD-1:0] len_q, len_d;
  logic [CNTWD-1:0] cnt_q, cnt_d, ones_q, ones_d;
  logic             bit_q, bit_d, vld_q, vld_d, done_q, done_d, busy_q, busy_d;

  logic [CNTWD-1:0] run_len;
  logic [CNTWD-1:0] k;
  logic [CNTWD-1:0] ones_base;
  logic [WIDTH-1:0] op_a, op_b, rngb_val;
  logic             op_mode, op_decor;
  logic             compute, sa, sb;
  logic             rng_clr, rnga_en, rngb_en;
  logic [WIDTH-1:0] seq_a, seq_b;

  assign run_len = CNTWD'(1) << len_q;

  // Generators sit at their first value whenever no run is active, so the
  // bit produced on the start edge can use them directly. Each generator
  // therefore always holds the value for the bit about to be registered.
  sc_sobol_rng #(.WIDTH(WIDTH)) u_rng_a (
    .clk   (clk),
    .rst   (rst),
    .clr   (rng_clr),
    .en    (rnga_en),
    .seq_o (seq_a)
  );

  sc_sobol_rng #(.WIDTH(WIDTH)) u_rng_b (
    .clk   (clk),
    .rst   (rst),
    .clr   (rng_clr),
    .en    (rngb_en),
    .seq_o (seq_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (abort_i)             state_d = IDLE;
        else if (cnt_q == run_len) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d = a_q; b_d = b_q; mode_d = mode_q; decor_d = decor_q; len_d = len_q;
    cnt_d = cnt_q; ones_d = ones_q;
    bit_d = 1'b0; vld_d = 1'b0; done_d = 1'b0;
    busy_d = (state_d == RUN);
    op_a = a_q; op_b = b_q; op_mode = mode_q; op_decor = decor_q;
    k = cnt_q; ones_base = ones_q;
    compute = 1'b0; rng_clr = 1'b0; rnga_en = 1'b0; rngb_en = 1'b0;
    rngb_val = '0; sa = 1'b0; sb = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Bit 0 comes straight from the inputs being latched this edge.
          a_d = a_i; b_d = b_i; mode_d = mode_i; decor_d = decor_i;
          len_d = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          op_a = a_i; op_b = b_i; op_mode = mode_i; op_decor = decor_i;
          k = '0; ones_base = '0;
          compute = 1'b1;
        end else begin
          rng_clr = 1'b1;
        end
      end
      RUN: begin
        if (abort_i || cnt_q == run_len) begin
          rng_clr = 1'b1;
          done_d  = !abort_i;
        end else begin
          compute = 1'b1;
        end
      end
      default: rng_clr = 1'b1;
    endcase

    if (compute) begin
      rngb_val = op_decor ? seq_b : k[WIDTH-1:0];
      sa       = op_a > seq_a;
      sb       = op_b > rngb_val;
      bit_d    = op_mode ? ~(sa ^ sb) : (sa & sb);
      vld_d    = 1'b1;
      ones_d   = ones_base + CNTWD'(bit_d);
      cnt_d    = k + 1'b1;
      rnga_en  = 1'b1;
      // B steps once per full A period: after the bit that used A's last value.
      rngb_en  = op_decor && (&k[WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; mode_q <= 1'b0; decor_q <= 1'b0; len_q <= '0;
      cnt_q <= '0; ones_q <= '0;
      bit_q <= 1'b0; vld_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; mode_q <= mode_d; decor_q <= decor_d; len_q <= len_d;
      cnt_q <= cnt_d; ones_q <= ones_d;
      bit_q <= bit_d; vld_q <= vld_d; done_q <= done_d; busy_q <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign bit_o     = bit_q;
  assign bit_vld_o = vld_q;
  assign done_o    = done_q;
  assign ones_o    = ones_q;

endmodule

// File: tb/tb_sc_mul_engine.sv
// tb/tb_sc_mul_engine.sv - self-checking bench for sc_mul_engine at WIDTH=4
module tb_sc_mul_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i, mode_i, decor_i;
  logic [3:0] len_i, a_i, b_i;
  logic       busy_o, bit_o, bit_vld_o, done_o;
  logic [8:0] ones_o;

  int checks = 0;
  int failures = 0;
  bit cap_bits [0:255];

  always #5 clk = ~clk;

  sc_mul_engine #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mode_i    (mode_i),
    .decor_i   (decor_i),
    .len_i     (len_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .bit_o     (bit_o),
    .bit_vld_o (bit_vld_o),
    .done_o    (done_o),
    .ones_o    (ones_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Dim-1 Sobol point n: gray code of n with its bits reversed.
  function automatic int sobol4(input int n);
    int g, r;
    g = (n ^ (n >> 1)) & 15;
    r = 0;
    for (int i = 0; i < 4; i++) if (((g >> i) & 1) == 1) r |= 1 << (3 - i);
    return r;
  endfunction

  function automatic bit exp_bit(input bit mode, input bit decor, input int a, input int b, input int j);
    int ra, rb;
    bit sa, sb;
    ra = sobol4(j % 16);
    rb = decor ? sobol4((j / 16) % 16) : (j % 16);
    sa = a > ra;
    sb = b > rb;
    return mode ? (sa == sb) : (sa && sb);
  endfunction

  // Behavioural model: phase 0 idle, 1 streaming, 2 done pulse.
  int m_phase = 0, m_idx = 0, m_len = 0, m_a = 0, m_b = 0, m_ones = 0;
  bit m_mode, m_decor, m_bit, m_vld, m_done, m_busy, m_armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_bit = 0; m_vld = 0; m_done = 0; m_busy = 0; m_ones = 0;
      m_armed = 1;
    end else begin
      m_done = 0;
      case (m_phase)
        0: begin
          if (start_i) begin
            m_mode = mode_i; m_decor = decor_i; m_a = a_i; m_b = b_i;
            m_len = (len_i > 8) ? 8 : int'(len_i);
            m_idx = 0; m_ones = 0; m_phase = 1; m_busy = 1;
            m_bit = exp_bit(m_mode, m_decor, m_a, m_b, 0);
            m_vld = 1; m_ones += int'(m_bit);
          end else m_vld = 0;
        end
        1: begin
          if (abort_i) begin
            m_phase = 0; m_busy = 0; m_vld = 0;
          end else if (m_idx + 1 == (1 << m_len)) begin
            m_phase = 2; m_busy = 0; m_vld = 0; m_done = 1;
          end else begin
            m_idx++;
            m_bit = exp_bit(m_mode, m_decor, m_a, m_b, m_idx);
            m_vld = 1; m_ones += int'(m_bit);
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("cyc_busy", int'(busy_o), int'(m_busy));
      check("cyc_vld", int'(bit_vld_o), int'(m_vld));
      check("cyc_done", int'(done_o), int'(m_done));
      check("cyc_ones", int'(ones_o), m_ones);
      if (m_vld) check("cyc_bit", int'(bit_o), int'(m_bit));
    end
  end

  task automatic launch(input bit m, input bit d, input int l, input int a, input int b, input bit ab);
    @(negedge clk);
    mode_i = m; decor_i = d; len_i = 4'(l); a_i = 4'(a); b_i = 4'(b);
    start_i = 1; abort_i = ab;
    @(negedge clk);
    start_i = 0; abort_i = 0;
    // Scramble inputs mid-run; the latched run must not notice.
    a_i = ~a_i; b_i = ~b_i; mode_i = ~m; decor_i = ~d; len_i = 4'd0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc, output int vc, output int bc);
    cyc = 1; vc = 0; bc = 0;
    while (done_o !== 1'b1 && cyc < budget) begin
      if (bit_vld_o === 1'b1) begin
        if (vc < 256) cap_bits[vc] = bit_o;
        vc++;
      end
      bc += int'(busy_o);
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, int'(done_o === 1'b1), 1);
  endtask

  int cyc, vc, bc;
  bit saw_done;

  initial begin
    rst = 1; start_i = 0; abort_i = 0; mode_i = 0; decor_i = 0;
    len_i = 0; a_i = 0; b_i = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_vld", int'(bit_vld_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_bit", int'(bit_o), 0);
    check("rst_ones", int'(ones_o), 0);
    rst = 0;

    check("model_sobol1", sobol4(1), 8);
    check("model_sobol10", sobol4(10), 15);
    check("model_sobol15", sobol4(15), 1);
    check("model_bit_ramp10", int'(exp_bit(0, 0, 15, 15, 10)), 0);

    // Unipolar, Sobol decorrelation, full length: exact a*b.
    launch(0, 1, 8, 8, 8, 0);
    wait_done("uni", 400, cyc, vc, bc);
    check("uni_ones", int'(ones_o), 64);
    check("uni_done_cycle", cyc, 257);
    check("uni_vld_count", vc, 256);

    // Bipolar exact: 12*4 + 4*12.
    launch(1, 1, 8, 12, 4, 0);
    wait_done("bip", 400, cyc, vc, bc);
    check("bip_ones", int'(ones_o), 96);
    check("bip_busy_count", bc, 256);

    // Ramp B, 16 bits; zeros where rngA=15 (idx 10) and rngB=15 (idx 15).
    launch(0, 0, 4, 15, 15, 0);
    wait_done("ramp", 100, cyc, vc, bc);
    check("ramp_ones", int'(ones_o), 14);
    check("ramp_vld_count", vc, 16);
    check("ramp_bit10", int'(cap_bits[10]), 0);
    check("ramp_bit15", int'(cap_bits[15]), 0);
    check("ramp_bit9", int'(cap_bits[9]), 1);

    // len above 2*WIDTH clamps to 8.
    launch(0, 1, 15, 8, 8, 0);
    wait_done("clamp", 400, cyc, vc, bc);
    check("clamp_ones", int'(ones_o), 64);
    check("clamp_vld_count", vc, 256);

    // Abort at the 5th bit; start pulse mid-run must be ignored.
    launch(0, 1, 8, 15, 15, 0);
    @(negedge clk);
    @(negedge clk);
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    @(negedge clk);
    check("abort_ones_before", int'(ones_o), 5);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    check("abort_busy", int'(busy_o), 0);
    check("abort_vld", int'(bit_vld_o), 0);
    saw_done = 0;
    repeat (6) begin
      saw_done |= (done_o === 1'b1);
      @(negedge clk);
    end
    check("abort_no_done", int'(saw_done), 0);
    check("abort_ones_hold", int'(ones_o), 5);

    // Start and abort together in IDLE: start wins; len=0 single bit.
    launch(0, 0, 0, 0, 15, 1);
    check("single_ones_cleared", int'(ones_o), 0);
    check("single_vld", int'(bit_vld_o), 1);
    check("single_bit", int'(bit_o), 0);
    wait_done("single", 20, cyc, vc, bc);
    check("single_done_cycle", cyc, 2);
    check("single_vld_count", vc, 1);
    check("single_ones", int'(ones_o), 0);

    // Reset in the middle of a run, then a clean rerun.
    launch(0, 1, 8, 8, 8, 0);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_vld", int'(bit_vld_o), 0);
    check("midrst_done", int'(done_o), 0);
    check("midrst_bit", int'(bit_o), 0);
    check("midrst_ones", int'(ones_o), 0);
    rst = 0;
    launch(0, 1, 8, 8, 8, 0);
    wait_done("rerun", 400, cyc, vc, bc);
    check("rerun_ones", int'(ones_o), 64);
    check("rerun_done_cycle", cyc, 257);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
